// File: rtl/instruction_fetch_if.sv
// IF-stage bus: hazard/redirect controls in, ROM address/word, IF/ID register and status out.
// Purely structural; no storage.
// Flow control is level-based: Stall and BranchTaken are sampled every clock.
interface instruction_fetch_if;
  logic        Stall;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic [31:0] InstrAddr;
  logic [31:0] InstrWord;
  logic [31:0] IF_ID_Instr;
  logic [31:0] IF_ID_PC4;
  logic        IF_ID_Valid;
  logic        FetchFault;
  logic        TightLoop;
  logic [31:0] FetchCount;

  // Fetch stage side
  modport master (
    input  Stall, BranchTaken, BranchTarget, InstrWord,
    output InstrAddr, IF_ID_Instr, IF_ID_PC4, IF_ID_Valid,
           FetchFault, TightLoop, FetchCount
  );

  // Core/ROM side
  modport slave (
    output Stall, BranchTaken, BranchTarget, InstrWord,
    input  InstrAddr, IF_ID_Instr, IF_ID_PC4, IF_ID_Valid,
           FetchFault, TightLoop, FetchCount
  );
endinterface

// File: rtl/instruction_fetch.sv
// MIPS IF stage: owns PC, fetches from combinational ROM, resolves J early, fills IF/ID.
// Latency: word at PC appears on IF_ID_Instr one clock after InstrAddr = PC; 1 instr/clock.
// Backpressure: Stall holds PC and IF/ID; BranchTaken overrides Stall; FAULT halts until rst.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter logic [31:0] FAULT_WORD     = 32'hFFFF_FFFF,
  parameter bit          LOOP_DETECT_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  instruction_fetch_if.master  bus
);

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] FAULT = 1'b1;

  localparam logic [5:0]  OP_J      = 6'b000010;
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        vld_q, vld_d;
  logic        fault_q, fault_d;
  logic        tight_q, tight_d;
  logic [31:0] cnt_q, cnt_d;

  logic [31:0] pc_plus4;
  logic        is_j;
  logic [31:0] j_target;

  // Next-state: redirect beats stall, stall beats fault detection, otherwise accept the word
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc4_d    = pc4_q;
    vld_d    = vld_q;
    fault_d  = fault_q;
    tight_d  = tight_q;
    cnt_d    = cnt_q;

    pc_plus4 = pc_q + 32'd4;
    is_j     = (bus.InstrWord[31:26] == OP_J);
    j_target = {pc_plus4[31:28], bus.InstrWord[25:0], 2'b00};

    if (state_q == RUN) begin
      if (bus.BranchTaken) begin
        // Low address bits of the redirect are dropped so fetch stays word aligned
        pc_d    = bus.BranchTarget & WORD_MASK;
        vld_d   = 1'b0;
        tight_d = 1'b0;
      end else if (bus.Stall) begin
        // Everything holds
      end else if (bus.InstrWord == FAULT_WORD) begin
        // Unmapped fetch: freeze PC and stop issuing
        state_d = FAULT;
        fault_d = 1'b1;
        vld_d   = 1'b0;
      end else begin
        instr_d = bus.InstrWord;
        pc4_d   = pc_plus4;
        vld_d   = 1'b1;
        cnt_d   = cnt_q + 32'd1;
        // J resolved here so no bubble and no delay slot is fetched
        pc_d    = is_j ? j_target : pc_plus4;
        tight_d = LOOP_DETECT_EN && is_j && (j_target == pc_q);
      end
    end else begin
      vld_d   = 1'b0;
      fault_d = 1'b1;
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      pc4_q   <= 32'd0;
      vld_q   <= 1'b0;
      fault_q <= 1'b0;
      tight_q <= 1'b0;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      vld_q   <= vld_d;
      fault_q <= fault_d;
      tight_q <= tight_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.InstrAddr   = pc_q;
  assign bus.IF_ID_Instr = instr_q;
  assign bus.IF_ID_PC4   = pc4_q;
  assign bus.IF_ID_Valid = vld_q;
  assign bus.FetchFault  = fault_q;
  assign bus.TightLoop   = tight_q;
  assign bus.FetchCount  = cnt_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: ROM stub + directed scenarios + randomized control traffic.
// Reference model tracks architectural PC/IF-ID/status from the stage's rules.
// Outputs are sampled 1ns after each rising edge.
module tb_instruction_fetch;
  localparam logic [31:0] FAULT = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instruction_fetch_if bus ();

  instruction_fetch #(
    .RESET_PC      (32'h0000_0000),
    .FAULT_WORD    (32'hFFFF_FFFF),
    .LOOP_DETECT_EN(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ROM image: 64 words at 0x00..0xFC, everything above is unmapped
  logic [31:0] mem [0:63];

  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a < 32'd256) return mem[a[7:2]];
    return FAULT;
  endfunction

  assign bus.InstrWord = rom(bus.InstrAddr);

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
  logic        m_vld, m_fault, m_tight;

  task automatic model_step(input bit r, input bit s, input bit b, input logic [31:0] t);
    logic [31:0] w, tgt;
    if (r) begin
      m_pc = 0; m_instr = 0; m_pc4 = 0; m_vld = 0;
      m_fault = 0; m_tight = 0; m_cnt = 0;
    end else if (m_fault) begin
      m_vld = 0;
    end else if (b) begin
      m_pc = {t[31:2], 2'b00};
      m_vld = 0;
      m_tight = 0;
    end else if (!s) begin
      w = rom(m_pc);
      if (w == FAULT) begin
        m_fault = 1;
        m_vld = 0;
      end else begin
        m_instr = w;
        m_pc4 = m_pc + 4;
        m_vld = 1;
        m_cnt = m_cnt + 1;
        if (w[31:26] == 6'b000010) begin
          tgt = {m_pc4[31:28], w[25:0], 2'b00};
          m_tight = (tgt == m_pc);
          m_pc = tgt;
        end else begin
          m_tight = 0;
          m_pc = m_pc4;
        end
      end
    end
  endtask

  // Apply one cycle of inputs, advance DUT and model, compare every output
  task automatic step(input bit r, input bit s, input bit b, input logic [31:0] t);
    rst = r;
    bus.Stall = s;
    bus.BranchTaken = b;
    bus.BranchTarget = t;
    model_step(r, s, b, t);
    @(posedge clk);
    #1;
    check_eq("InstrAddr", bus.InstrAddr, m_pc);
    check_eq("IF_ID_Valid", {31'd0, bus.IF_ID_Valid}, {31'd0, m_vld});
    check_eq("FetchFault", {31'd0, bus.FetchFault}, {31'd0, m_fault});
    check_eq("TightLoop", {31'd0, bus.TightLoop}, {31'd0, m_tight});
    check_eq("FetchCount", bus.FetchCount, m_cnt);
    if (m_vld || r) begin
      check_eq("IF_ID_Instr", bus.IF_ID_Instr, m_instr);
      check_eq("IF_ID_PC4", bus.IF_ID_PC4, m_pc4);
    end
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] hold_instr, hold_cnt;
    int n;

    rst = 1'b1;
    bus.Stall = 1'b0;
    bus.BranchTaken = 1'b0;
    bus.BranchTarget = 32'd0;

    // Random non-jump, non-fault filler
    for (int i = 0; i < 64; i++) begin
      do w = $urandom; while (w[31:26] == 6'b000010 || w == FAULT);
      mem[i] = w;
    end
    mem[0]  = 32'h2400_0120;
    mem[24] = 32'h0800_001C;   // 0x60: J 0x70
    mem[32] = 32'h0800_0020;   // 0x80: J 0x80 (self loop)
    mem[36] = FAULT;           // 0x90: unmapped marker

    // Reset state
    step(1, 0, 0, 0);
    check_eq("rst_addr", bus.InstrAddr, 32'd0);
    check_eq("rst_cnt", bus.FetchCount, 32'd0);

    // First fetch
    step(0, 0, 0, 0);
    check_eq("first_addr", bus.InstrAddr, 32'd4);
    check_eq("first_instr", bus.IF_ID_Instr, 32'h2400_0120);
    check_eq("first_pc4", bus.IF_ID_PC4, 32'd4);
    check_eq("first_vld", {31'd0, bus.IF_ID_Valid}, 32'd1);
    check_eq("first_cnt", bus.FetchCount, 32'd1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check_eq("addr12", bus.InstrAddr, 32'd12);
    step(0, 0, 0, 0);

    // Stall three cycles at PC 16
    hold_instr = bus.IF_ID_Instr;
    hold_cnt = bus.FetchCount;
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0);
      check_eq("stall_addr", bus.InstrAddr, 32'd16);
      check_eq("stall_instr", bus.IF_ID_Instr, hold_instr);
      check_eq("stall_cnt", bus.FetchCount, hold_cnt);
    end
    step(0, 0, 0, 0);
    check_eq("release_addr", bus.InstrAddr, 32'd20);

    // Run into the self-loop at 0x80 (via the J at 0x60)
    n = 0;
    while (bus.InstrAddr != 32'd128 && n < 200) begin
      step(0, 0, 0, 0);
      n++;
    end
    check_eq("reach_loop", bus.InstrAddr, 32'd128);
    for (int i = 0; i < 4; i++) begin
      hold_cnt = bus.FetchCount;
      step(0, 0, 0, 0);
      check_eq("loop_addr", bus.InstrAddr, 32'd128);
      check_eq("loop_tight", {31'd0, bus.TightLoop}, 32'd1);
      check_eq("loop_cnt", bus.FetchCount, hold_cnt + 32'd1);
    end

    // Redirect wins over stall, unaligned target
    step(0, 1, 1, 32'h43);
    check_eq("br_addr", bus.InstrAddr, 32'h40);
    check_eq("br_vld", {31'd0, bus.IF_ID_Valid}, 32'd0);
    check_eq("br_tight", {31'd0, bus.TightLoop}, 32'd0);
    step(0, 0, 0, 0);
    check_eq("br_fetch", bus.IF_ID_PC4, 32'h44);

    // Redirect into unmapped word
    step(0, 0, 1, 32'h90);
    step(0, 0, 0, 0);
    check_eq("fault_flag", {31'd0, bus.FetchFault}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 32'h10);
      check_eq("fault_frozen", bus.InstrAddr, 32'h90);
    end

    // Reset out of FAULT
    step(1, 0, 0, 0);
    check_eq("refault_flag", {31'd0, bus.FetchFault}, 32'd0);
    step(0, 0, 0, 0);
    check_eq("resume_instr", bus.IF_ID_Instr, 32'h2400_0120);

    // Randomized control traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, s, b;
      r = ($urandom_range(0, 99) < 2) || (m_fault && $urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 99) < 25);
      b = ($urandom_range(0, 99) < 10);
      step(r, s, b, $urandom_range(0, 259));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
